// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Each digit slot is REFRESH_DIV cycles long, and the last BLANK_CYC cycles of the slot are blanked.
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       mask_wr,
    input  logic [7:0] mask_data,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic [2:0] digit_idx,
    output logic       frame_tick
);
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(REFRESH_DIV - BLANK_CYC);

    typedef enum logic {DRIVE, BLANK} phase_e;

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       mask_q, mask_d;
    logic [3:0]       digit_q [8];
    logic [3:0]       digit_d [8];
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             tick_q, tick_d;
    logic             wrap;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        idx_d   = wrap ? idx_q + 3'd1 : idx_q;
        tick_d  = wrap && (idx_q == 3'd7);
        phase_d = phase_q;
        case (phase_q)
            DRIVE:   if (cnt_d == BLANK_START) phase_d = BLANK;
            BLANK:   if (wrap) phase_d = DRIVE;
            default: phase_d = DRIVE;
        endcase
    end

    always_comb begin
        mask_d = mask_wr ? mask_data : mask_q;
        for (int i = 0; i < 8; i++) begin
            digit_d[i] = (wr_en && (wr_addr == 3'(i))) ? wr_data : digit_q[i];
        end
    end

    // Outputs are derived from post-edge state, so a write shows on seg at the very next edge.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        if (phase_d == DRIVE && mask_d[idx_d]) begin
            an_d  = ~(8'b1 << idx_d);
            seg_d = hex7(digit_d[idx_d]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= DRIVE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mask_q  <= 8'hFF;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            tick_q  <= 1'b0;
            for (int i = 0; i < 8; i++) digit_q[i] <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
            for (int i = 0; i < 8; i++) digit_q[i] <= digit_d[i];
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign digit_idx  = idx_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized and directed checks of seven_seg_scan_ctrl against a slot/phase reference model.
module tb_seven_seg_scan_ctrl;
    localparam int DIV = 4;
    localparam int BLK = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       mask_wr = 1'b0;
    logic [7:0] mask_data = '0;
    logic [7:0] an;
    logic [6:0] seg;
    logic [2:0] digit_idx;
    logic       frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state: position in the frame plus stored contents.
    int         m_cnt, m_idx, m_tick;
    bit         m_rstout;
    logic [3:0] m_dig [8];
    logic [7:0] m_mask;
    logic [6:0] hex_tab [16];

    seven_seg_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mask_wr(mask_wr), .mask_data(mask_data), .an(an), .seg(seg),
        .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_an();
        logic [7:0] v;
        if (m_rstout || m_cnt >= DIV - BLK || !m_mask[m_idx]) return 8'hFF;
        v = 8'h01 << m_idx;
        return ~v;
    endfunction

    function automatic logic [6:0] exp_seg();
        if (m_rstout || m_cnt >= DIV - BLK || !m_mask[m_idx]) return 7'h7F;
        return hex_tab[m_dig[m_idx]];
    endfunction

    function automatic logic [18:0] exp_all();
        return {exp_an(), exp_seg(), 3'(m_idx), 1'(m_tick)};
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_tick = 0; m_rstout = 1'b1; m_mask = 8'hFF;
            for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
        end else begin
            if (mask_wr) m_mask = mask_data;
            if (wr_en) m_dig[wr_addr] = wr_data;
            m_tick = (m_cnt == DIV - 1 && m_idx == 7) ? 1 : 0;
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_cnt++;
            end
            m_rstout = 1'b0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if ($countones(~an) > 1 || (an == 8'hFF && seg !== 7'h7F)) begin
                n_fail++;
                $display("FAIL invariant: an=%h seg=%h, required <=1 anode low and seg=7F when an=FF", an, seg);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        n_tests++;
        if ({an, seg, digit_idx, frame_tick} !== {8'hFF, 7'h7F, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: an=%h seg=%h idx=%0d tick=%b, required FF 7F 0 0", an, seg, digit_idx, frame_tick);
        end
        $display("[TB] reset applied");
    endtask

    task automatic test_scan();
        int ticks = 0;
        for (int c = 0; c < 64; c++) begin
            step();
            if (c >= 16 && c < 48) ticks += int'(frame_tick);
            n_tests++;
            if ({an, seg, digit_idx, frame_tick} !== exp_all()) begin
                n_fail++;
                $display("FAIL scan c%0d: got %h/%h/%0d/%b exp %h/%h/%0d/%0d", c, an, seg, digit_idx,
                         frame_tick, exp_an(), exp_seg(), m_idx, m_tick);
            end
        end
        n_tests++;
        if (ticks != 1) begin
            n_fail++;
            $display("FAIL frame_tick_rate: got %0d ticks in 32 cycles, required 1", ticks);
        end
    endtask

    task automatic test_digits();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1);
            $display("[TB] write digit %0d = %h", i, wr_data);
            step();
        end
        wr_en = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            n_tests++;
            if ({an, seg, digit_idx, frame_tick} !== exp_all()) begin
                n_fail++;
                $display("FAIL digits c%0d: got %h/%h/%0d/%b exp %h/%h/%0d/%0d", c, an, seg, digit_idx,
                         frame_tick, exp_an(), exp_seg(), m_idx, m_tick);
            end
            if (m_idx == 3 && m_cnt < DIV - BLK) begin
                n_tests++;
                if (seg !== 7'h19) begin
                    n_fail++;
                    $display("FAIL digit3_seg: got %h required 19", seg);
                end
            end
            if (m_idx == 7 && m_cnt < DIV - BLK) begin
                n_tests++;
                if (seg !== 7'h00) begin
                    n_fail++;
                    $display("FAIL digit7_seg: got %h required 00", seg);
                end
            end
        end
    endtask

    task automatic test_mask();
        mask_wr = 1'b1; mask_data = 8'b1010_1010;
        $display("[TB] mask write %h", mask_data);
        step();
        mask_wr = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            n_tests++;
            if ({an, seg, digit_idx, frame_tick} !== exp_all()) begin
                n_fail++;
                $display("FAIL mask c%0d: got %h/%h/%0d/%b exp %h/%h/%0d/%0d", c, an, seg, digit_idx,
                         frame_tick, exp_an(), exp_seg(), m_idx, m_tick);
            end
            if (m_idx % 2 == 0) begin
                n_tests++;
                if (an !== 8'hFF || seg !== 7'h7F) begin
                    n_fail++;
                    $display("FAIL masked_slot%0d: an=%h seg=%h required FF 7F", m_idx, an, seg);
                end
            end
        end
    endtask

    task automatic test_midslot_write();
        bit found = 1'b0;
        mask_wr = 1'b1; mask_data = 8'hFF;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h0;
        step();
        mask_wr = 1'b0; wr_en = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            step();
            if (m_idx == 2 && m_cnt == 1) found = 1'b1;
        end
        n_tests++;
        if (!found || seg !== 7'h40 || an !== 8'hFB) begin
            n_fail++;
            $display("FAIL midslot_pre: found=%b an=%h seg=%h required FB 40", found, an, seg);
        end
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hF;
        $display("[TB] mid-slot write digit 2 = F");
        step();
        wr_en = 1'b0;
        n_tests++;
        if (seg !== 7'h0E || an !== 8'hFB) begin
            n_fail++;
            $display("FAIL midslot_write: an=%h seg=%h required FB 0E", an, seg);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 4'($urandom_range(0, 15));
            mask_wr   = ($urandom_range(0, 9) == 0);
            mask_data = 8'($urandom_range(0, 255));
            step();
            n_tests++;
            if ({an, seg, digit_idx, frame_tick} !== exp_all()) begin
                n_fail++;
                $display("FAIL random c%0d: got %h/%h/%0d/%b exp %h/%h/%0d/%0d", c, an, seg, digit_idx,
                         frame_tick, exp_an(), exp_seg(), m_idx, m_tick);
            end
        end
        wr_en = 1'b0; mask_wr = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 16; c++) begin
            wr_en = 1'b1; wr_addr = 3'(c % 8); wr_data = 4'(15 - c);
            mask_wr = 1'b1; mask_data = 8'(8'hFF ^ (8'h01 << (c % 8)) ^ 8'hFF) | 8'h0F;
            step();
            n_tests++;
            if ({an, seg, digit_idx, frame_tick} !== exp_all()) begin
                n_fail++;
                $display("FAIL back_to_back c%0d: got %h/%h/%0d/%b exp %h/%h/%0d/%0d", c, an, seg,
                         digit_idx, frame_tick, exp_an(), exp_seg(), m_idx, m_tick);
            end
        end
        wr_en = 1'b0; mask_wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        mask_wr = 1'b1; mask_data = 8'hFF;
        step();
        mask_wr = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            step();
            if (m_idx == 5 && m_cnt == 1) found = 1'b1;
        end
        n_tests++;
        if (!found || an !== 8'hDF) begin
            n_fail++;
            $display("FAIL reset_mid_pre: found=%b an=%h required DF", found, an);
        end
        rst = 1'b1;
        $display("[TB] reset asserted in slot 5");
        step();
        rst = 1'b0;
        n_tests++;
        if ({an, seg, digit_idx, frame_tick} !== {8'hFF, 7'h7F, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: an=%h seg=%h idx=%0d tick=%b, required FF 7F 0 0", an, seg, digit_idx, frame_tick);
        end
        step();
        n_tests++;
        if (an !== 8'hFE || seg !== 7'h40 || digit_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release: an=%h seg=%h idx=%0d, required FE 40 0", an, seg, digit_idx);
        end
    endtask

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        test_reset();
        test_scan();
        test_digits();
        test_mask();
        test_midslot_write();
        test_random();
        test_back_to_back();
        test_reset_mid();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
